// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type and the width helper for FIFO fill counters.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

  // A count must represent 0..depth inclusive, hence one bit more than the pointer.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int UART_FIFO_DEPTH   = 16;
  localparam int UART_FIFO_COUNT_W = count_width(UART_FIFO_DEPTH);

endpackage

// File: rtl/sync_fifo.sv
// Generic circular-buffer FIFO with explicit fill count, registered overflow pulse
// and a read port that shows the head entry directly from the register array.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push, pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign pop   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push  = wr_en && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = wr_en && !push;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage keeps its contents across reset; only pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of the UART transmitter: absorbs producer bursts and
// presents the head byte on the TX_DRDY/TX_DI/TX_DONE handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DEPTH     = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          WR_EN,
  input  logic [DATA_BITS-1:0]          WR_DATA,
  output logic                          FULL,
  output logic                          EMPTY,
  output logic [count_width(DEPTH)-1:0] COUNT,
  output logic                          OVERFLOW,
  output logic                          TX_DRDY,
  output logic [DATA_BITS-1:0]          TX_DI,
  input  logic                          TX_DONE
);

  logic [DATA_BITS-1:0] head;
  logic                 pop_req;

  // A TX_DONE from a frame launched before a reset lands on an empty buffer and is dropped.
  assign pop_req = TX_DONE && !EMPTY;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .wr_en    (WR_EN),
    .wr_data  (WR_DATA),
    .rd_en    (pop_req),
    .rd_data  (head),
    .full     (FULL),
    .empty    (EMPTY),
    .count    (COUNT),
    .overflow (OVERFLOW)
  );

  assign TX_DRDY = !EMPTY;
  assign TX_DI   = EMPTY ? '0 : head;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench for uart_tx_fifo with a behavioural transmitter model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = count_width(DEPTH);

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WR_EN;
  uart_byte_t  WR_DATA;
  logic        FULL, EMPTY, OVERFLOW, TX_DRDY, TX_DONE;
  logic [CW-1:0] COUNT;
  uart_byte_t  TX_DI;

  logic        uart_done;
  logic        manual_done;
  assign TX_DONE = uart_done | manual_done;

  int          checks   = 0;
  int          failures = 0;
  uart_byte_t  model_q[$];
  uart_byte_t  sb_q[$];
  logic        exp_ovf;
  bit          tx_en = 0;
  bit          rand_frames = 0;
  bit          uart_busy = 0;
  uart_byte_t  latched;
  uart_byte_t  last_tx;
  uart_byte_t  mon_exp;
  int          tx_count  = 0;
  int          max_count = 0;

  uart_tx_fifo #(
    .DATA_BITS (UART_DATA_BITS),
    .DEPTH     (DEPTH)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .WR_EN    (WR_EN),
    .WR_DATA  (WR_DATA),
    .FULL     (FULL),
    .EMPTY    (EMPTY),
    .COUNT    (COUNT),
    .OVERFLOW (OVERFLOW),
    .TX_DRDY  (TX_DRDY),
    .TX_DI    (TX_DI),
    .TX_DONE  (TX_DONE)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the buffer is just an ordered queue bounded at DEPTH.
  initial begin
    logic rst_s, wr_s, done_s;
    uart_byte_t data_s;
    bit pop_e, push_e;
    exp_ovf = 1'b0;
    forever begin
      @(posedge CLK);
      rst_s  = RST;
      wr_s   = WR_EN;
      done_s = TX_DONE;
      data_s = WR_DATA;
      #1;
      if (rst_s) begin
        model_q.delete();
        sb_q.delete();
        exp_ovf = 1'b0;
      end else begin
        pop_e   = done_s && (model_q.size() > 0);
        push_e  = wr_s && ((model_q.size() < DEPTH) || pop_e);
        exp_ovf = wr_s && !push_e;
        if (pop_e) void'(model_q.pop_front());
        if (push_e) begin
          model_q.push_back(data_s);
          sb_q.push_back(data_s);
        end
      end
      if (int'(COUNT) > max_count) max_count = int'(COUNT);
      chk("count",    32'(COUNT),    32'(model_q.size()));
      chk("empty",    32'(EMPTY),    32'(model_q.size() == 0));
      chk("full",     32'(FULL),     32'(model_q.size() == DEPTH));
      chk("tx_drdy",  32'(TX_DRDY),  32'(model_q.size() != 0));
      chk("tx_di",    32'(TX_DI),    (model_q.size() != 0) ? 32'(model_q[0]) : 32'h0);
      chk("overflow", 32'(OVERFLOW), 32'(exp_ovf));
    end
  end

  // Transmitter model; frame length compressed to a few cycles to keep runtime short.
  initial begin
    int left;
    uart_done = 1'b0;
    left = 0;
    forever begin
      @(negedge CLK);
      uart_done = 1'b0;
      if (uart_busy) begin
        if (left == 0) begin
          uart_done = 1'b1;
          uart_busy = 0;
        end else begin
          left--;
        end
      end else if (tx_en && TX_DRDY && !RST) begin
        uart_busy = 1;
        latched   = TX_DI;
        left      = rand_frames ? int'($urandom_range(12, 2)) : 6;
      end
    end
  end

  // Monitor: every accepted TX_DONE consumes the head, which must match the scoreboard.
  initial forever begin
    @(posedge CLK);
    if (!RST && TX_DONE && TX_DRDY) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected: got 0x%0h expected no byte", TX_DI);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("tx_byte", 32'(TX_DI), 32'(mon_exp));
      end
      if (uart_done) chk("tx_stable", 32'(TX_DI), 32'(latched));
      last_tx = TX_DI;
      tx_count++;
    end
  end

  task automatic push(input uart_byte_t d);
    WR_EN   = 1'b1;
    WR_DATA = d;
    @(negedge CLK);
    WR_EN   = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (EMPTY && !uart_busy) break;
      @(negedge CLK);
    end
    checks++;
    if (i >= limit) begin
      failures++;
      $display("FAIL %s: got no drain within %0d cycles required empty and idle", name, limit);
    end
  endtask

  initial begin
    int n0, n;
    WR_EN = 1'b0;
    WR_DATA = '0;
    manual_done = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("por_empty", 32'(EMPTY), 32'h1);
    chk("por_drdy",  32'(TX_DRDY), 32'h0);

    // Reset with a frame in flight; its TX_DONE later lands on an empty buffer.
    push(8'hA5);
    tx_en = 1;
    repeat (2) @(negedge CLK);
    tx_en = 0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    chk("rst_empty", 32'(EMPTY), 32'h1);
    chk("rst_count", 32'(COUNT), 32'h0);
    chk("rst_drdy",  32'(TX_DRDY), 32'h0);
    chk("rst_di",    32'(TX_DI), 32'h0);
    chk("rst_full",  32'(FULL), 32'h0);
    wait_idle("stale_frame", 50);
    repeat (2) @(negedge CLK);
    chk("stale_empty", 32'(EMPTY), 32'h1);
    chk("stale_count", 32'(COUNT), 32'h0);

    // Single byte write-through.
    push(8'h3C);
    chk("single_drdy",  32'(TX_DRDY), 32'h1);
    chk("single_di",    32'(TX_DI), 32'h3C);
    chk("single_count", 32'(COUNT), 32'h1);
    n0 = tx_count;
    tx_en = 1;
    wait_idle("single_drain", 100);
    tx_en = 0;
    chk("single_empty", 32'(EMPTY), 32'h1);
    chk("single_frames", 32'(tx_count - n0), 32'h1);

    // Burst fill, dropped push, then push+pop at full.
    for (int i = 0; i < DEPTH; i++) push(uart_byte_t'(i));
    chk("burst_full",  32'(FULL), 32'h1);
    chk("burst_count", 32'(COUNT), 32'(DEPTH));
    chk("burst_head",  32'(TX_DI), 32'h00);
    push(8'hFF);
    chk("ovf_pulse", 32'(OVERFLOW), 32'h1);
    chk("ovf_count", 32'(COUNT), 32'(DEPTH));
    @(negedge CLK);
    chk("ovf_clear", 32'(OVERFLOW), 32'h0);
    WR_EN = 1'b1;
    WR_DATA = 8'h77;
    manual_done = 1'b1;
    @(negedge CLK);
    WR_EN = 1'b0;
    manual_done = 1'b0;
    chk("simul_count", 32'(COUNT), 32'(DEPTH));
    chk("simul_ovf",   32'(OVERFLOW), 32'h0);
    chk("simul_full",  32'(FULL), 32'h1);
    chk("simul_head",  32'(TX_DI), 32'h01);
    n0 = tx_count;
    tx_en = 1;
    wait_idle("burst_drain", 400);
    chk("burst_frames", 32'(tx_count - n0), 32'(DEPTH));
    chk("burst_last",   32'(last_tx), 32'h77);
    chk("burst_empty",  32'(EMPTY), 32'h1);

    // Random traffic with wrap-around and occasional overflow.
    rand_frames = 1;
    n = 0;
    for (int cyc = 0; cyc < 20000 && n < 1000; cyc++) begin
      if ($urandom_range(99, 0) < 30) begin
        WR_EN = 1'b1;
        WR_DATA = uart_byte_t'($urandom);
        n++;
      end else begin
        WR_EN = 1'b0;
      end
      @(negedge CLK);
    end
    WR_EN = 1'b0;
    chk("rand_pushes", 32'(n), 32'd1000);
    wait_idle("rand_drain", 500);
    chk("rand_sb_left", 32'(sb_q.size()), 32'h0);
    chk("rand_empty",   32'(EMPTY), 32'h1);
    chk("rand_max_cnt", 32'(max_count <= DEPTH), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
